pet_stats: RTL and testbench
============================

# pet_stats

Pet-stat engine for the virtual-pet game. It consumes the periodic `done` tick from the game timer and decays three saturating stats: fullness, energy and joy. It applies the player's feed, play and sleep button pulses and runs the awake/asleep/dead state machine. Its stat, mood and state outputs feed the display and sprite-select logic directly.

## Interface
Parameters:
- `STAT_BITS`, default 3: width of each stat. `MAX` = 2^STAT_BITS − 1. `HALF` = MAX >> 1.
- `DECAY_TICKS`, default 10: number of tick rising edges per decay event. Must be ≥ 1.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low.
- `tick`, input, 1: timer `done`. Treated as a level; only its rising edge counts.
- `feed_pulse`, input, 1: one-cycle button pulse.
- `play_pulse`, input, 1: one-cycle button pulse.
- `sleep_pulse`, input, 1: one-cycle button pulse.
- `fullness`, output, STAT_BITS: registered.
- `energy`, output, STAT_BITS: registered.
- `joy`, output, STAT_BITS: registered.
- `mood`, output, 2: 0 HAPPY, 1 OK, 2 SAD, 3 DEAD. Combinational from registered state.
- `sleeping`, output, 1: high in ASLEEP.
- `dead`, output, 1: high in DEAD.
- `decay_strobe`, output, 1: registered one-cycle pulse per decay event.

## Operation
- **Reset values:** fullness = energy = joy = MAX; state AWAKE; decay counter 0; tick_prev = 1; decay_strobe 0; mood 0; sleeping 0; dead 0.
- **Edge detect:** tick_edge = tick & ~tick_prev. tick_prev updates every cycle. A tick held high for several cycles counts once. A tick already high when reset is released is not an edge.
- **Decay counter:**
  - Width is clog2(DECAY_TICKS), minimum 1 bit.
  - Increments on tick_edge.
  - On a tick_edge while the counter equals DECAY_TICKS−1, the counter wraps to 0 and a decay event fires.
  - The counter keeps running in ASLEEP and freezes in DEAD.
- **Decay event, AWAKE:** fullness −1, energy −1, joy −1. Each saturates at 0.
- **Decay event, ASLEEP:** fullness −1 (saturating at 0), energy +2 (saturating at MAX), joy unchanged.
- **Buttons:** only one is honoured per cycle, with priority feed > play > sleep. The others are dropped, not queued.
  - feed, AWAKE only: fullness +2, saturating at MAX.
  - play, AWAKE only and only if energy > 0: joy +2 (saturating at MAX), energy −1.
  - sleep: AWAKE → ASLEEP, or ASLEEP → AWAKE.
  - feed and play are ignored in ASLEEP.
- **Simultaneous decay event and button:** both take effect in the same cycle. Decay is applied first, then the button, with saturation at each step. The play energy check uses the post-decay energy.
- **State transitions:** evaluated on the updated stats.
  - ASLEEP → AWAKE automatically when energy reaches MAX after a decay event.
  - Any state → DEAD when fullness == 0 and joy == 0.
  - DEAD takes precedence over any other transition in that cycle.
- **DEAD:** terminal. All inputs are ignored and stats are frozen. Only reset exits DEAD.
- **Mood:** the first matching rule applies.
  1. DEAD → 3.
  2. Any stat == 0 → 2.
  3. min(fullness, energy, joy) < HALF → 1.
  4. Otherwise → 0.

## Timing
- All state updates happen on the clock edge that samples tick_edge or a button. New values are visible the following cycle, so latency is 1 cycle from input to stat change.
- decay_strobe is high for exactly the cycle in which the decayed stats first appear.
- mood, sleeping and dead change in the same cycle as the stats.
- Back-to-back pulses on consecutive cycles are each honoured.
- Asynchronous reset mid-operation clears everything immediately. A partially accumulated decay count is discarded.

## Test plan
Use MAX = 7, DECAY_TICKS = 4 for all scenarios.
1. **Reset:** assert reset for 3 cycles → outputs 7/7/7, mood 0, sleeping 0, dead 0, decay_strobe 0. Release reset with tick high → no edge is counted.
2. **Decay and edge detect:** 4 tick edges, one of them held high for 5 cycles → exactly one decay_strobe; stats 6/6/6; mood 0.
3. **Saturation and play:** feed at fullness 6 → 7. Play at energy 6, joy 6 → joy 7, energy 5. Play at energy 0 → no change.
4. **Sleep and auto-wake:** from energy 2, sleep_pulse, then 3 decay events → energy 4, 6, 7, and sleeping drops after the third event; fullness drops by 3; feed while asleep is ignored.
5. **Death:** 7 decay events with no input → fullness 0, joy 0, dead 1, mood 3. Feed, sleep and ticks afterwards have no effect. Reset restores 7/7/7.
6. **Simultaneous events:**
   - Decay event and feed in the same cycle at fullness 3 → fullness 4.
   - feed and play in the same cycle → only feed applied.
   - Reset asserted after 3 tick edges → the counter is discarded and the next decay needs 4 fresh edges.

Source files
------------

// File: rtl/pet_stats.sv
// Virtual-pet stat engine: tick-driven decay of fullness/energy/joy, button
// handling and the awake/asleep/dead state machine.
module pet_stats #(
  parameter int STAT_BITS   = 3,
  parameter int DECAY_TICKS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 feed_pulse,
  input  logic                 play_pulse,
  input  logic                 sleep_pulse,
  output logic [STAT_BITS-1:0] fullness,
  output logic [STAT_BITS-1:0] energy,
  output logic [STAT_BITS-1:0] joy,
  output logic [1:0]           mood,
  output logic                 sleeping,
  output logic                 dead,
  output logic                 decay_strobe
);

  localparam int SW    = STAT_BITS + 1;
  localparam int CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [STAT_BITS-1:0] MAX      = '1;
  localparam logic [STAT_BITS-1:0] HALF     = MAX >> 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DECAY_TICKS - 1);

  typedef enum logic [1:0] {ST_AWAKE, ST_ASLEEP, ST_DEAD} state_t;

  state_t               state_reg, state_next;
  logic [STAT_BITS-1:0] full_reg, full_next, full_d;
  logic [STAT_BITS-1:0] energy_reg, energy_next, energy_d;
  logic [STAT_BITS-1:0] joy_reg, joy_next, joy_d;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 tick_prev_reg;
  logic                 strobe_reg;
  logic                 tick_edge;
  logic                 decay_event;

  function automatic logic [STAT_BITS-1:0] sat_add2(input logic [STAT_BITS-1:0] v);
    logic [SW-1:0] s;
    s = {1'b0, v} + SW'(2);
    return (s > {1'b0, MAX}) ? MAX : s[STAT_BITS-1:0];
  endfunction

  function automatic logic [STAT_BITS-1:0] sat_dec(input logic [STAT_BITS-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // tick_prev resets high so a tick already asserted at reset release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_AWAKE;
      full_reg      <= MAX;
      energy_reg    <= MAX;
      joy_reg       <= MAX;
      cnt_reg       <= '0;
      tick_prev_reg <= 1'b1;
      strobe_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      full_reg      <= full_next;
      energy_reg    <= energy_next;
      joy_reg       <= joy_next;
      cnt_reg       <= cnt_next;
      tick_prev_reg <= tick;
      strobe_reg    <= decay_event;
    end
  end

  always_comb begin
    tick_edge   = tick & ~tick_prev_reg;
    decay_event = 1'b0;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    full_d      = full_reg;
    energy_d    = energy_reg;
    joy_d       = joy_reg;
    full_next   = full_reg;
    energy_next = energy_reg;
    joy_next    = joy_reg;

    if (state_reg != ST_DEAD) begin
      if (tick_edge) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next    = '0;
          decay_event = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      if (decay_event) begin
        full_d = sat_dec(full_reg);
        if (state_reg == ST_AWAKE) begin
          energy_d = sat_dec(energy_reg);
          joy_d    = sat_dec(joy_reg);
        end else begin
          energy_d = sat_add2(energy_reg);
        end
      end

      full_next   = full_d;
      energy_next = energy_d;
      joy_next    = joy_d;

      // A lower-priority pulse is dropped even when the winning one has no effect
      if (feed_pulse) begin
        if (state_reg == ST_AWAKE) full_next = sat_add2(full_d);
      end else if (play_pulse) begin
        if (state_reg == ST_AWAKE && energy_d != '0) begin
          joy_next    = sat_add2(joy_d);
          energy_next = energy_d - 1'b1;
        end
      end else if (sleep_pulse) begin
        state_next = (state_reg == ST_AWAKE) ? ST_ASLEEP : ST_AWAKE;
      end

      if (state_reg == ST_ASLEEP && decay_event && energy_d == MAX)
        state_next = ST_AWAKE;

      if (full_next == '0 && joy_next == '0)
        state_next = ST_DEAD;
    end
  end

  always_comb begin
    if (state_reg == ST_DEAD)
      mood = 2'd3;
    else if (full_reg == '0 || energy_reg == '0 || joy_reg == '0)
      mood = 2'd2;
    else if (full_reg < HALF || energy_reg < HALF || joy_reg < HALF)
      mood = 2'd1;
    else
      mood = 2'd0;
  end

  assign fullness     = full_reg;
  assign energy       = energy_reg;
  assign joy          = joy_reg;
  assign sleeping     = (state_reg == ST_ASLEEP);
  assign dead         = (state_reg == ST_DEAD);
  assign decay_strobe = strobe_reg;

endmodule

// File: tb/tb_pet_stats.sv
// Scoreboard bench for pet_stats: a reference model queues the expected
// outputs for every driven cycle; these are popped and compared after the edge.
module tb_pet_stats;

  localparam int SB = 3;
  localparam int DT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          feed_pulse, play_pulse, sleep_pulse;
  logic [SB-1:0] fullness, energy, joy;
  logic [1:0]    mood;
  logic          sleeping, dead, decay_strobe;

  pet_stats #(.STAT_BITS(SB), .DECAY_TICKS(DT)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .feed_pulse   (feed_pulse),
    .play_pulse   (play_pulse),
    .sleep_pulse  (sleep_pulse),
    .fullness     (fullness),
    .energy       (energy),
    .joy          (joy),
    .mood         (mood),
    .sleeping     (sleeping),
    .dead         (dead),
    .decay_strobe (decay_strobe)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int strobe_cnt   = 0;

  // Reference model: state 0 awake, 1 asleep, 2 dead
  int m_f, m_e, m_j, m_st, m_cnt, m_tp, m_dec;
  logic [13:0] exp_q[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  function automatic int model_mood();
    int mn;
    mn = (m_f < m_e) ? m_f : m_e;
    mn = (mn < m_j) ? mn : m_j;
    if (m_st == 2) return 3;
    if (mn == 0) return 2;
    if (mn < 3) return 1;
    return 0;
  endfunction

  function automatic logic [13:0] model_pack();
    return {3'(m_f), 3'(m_e), 3'(m_j), 2'(model_mood()),
            m_st == 1, m_st == 2, m_dec != 0};
  endfunction

  function automatic logic [13:0] dut_pack();
    return {fullness, energy, joy, mood, sleeping, dead, decay_strobe};
  endfunction

  task automatic model_reset();
    m_f = 7; m_e = 7; m_j = 7; m_st = 0; m_cnt = 0; m_tp = 1; m_dec = 0;
  endtask

  task automatic model_step(input logic t, input logic f, input logic p, input logic s);
    int edge_seen, st_old;
    edge_seen = (t && !m_tp) ? 1 : 0;
    m_tp  = t ? 1 : 0;
    m_dec = 0;
    st_old = m_st;
    if (m_st != 2) begin
      if (edge_seen != 0) begin
        if (m_cnt == DT - 1) begin m_cnt = 0; m_dec = 1; end
        else m_cnt++;
      end
      if (m_dec != 0) begin
        m_f = clamp(m_f - 1);
        if (st_old == 0) begin m_e = clamp(m_e - 1); m_j = clamp(m_j - 1); end
        else m_e = clamp(m_e + 2);
      end
      if (f) begin
        if (st_old == 0) m_f = clamp(m_f + 2);
      end else if (p) begin
        if (st_old == 0 && m_e > 0) begin m_j = clamp(m_j + 2); m_e--; end
      end else if (s) begin
        m_st = (st_old == 0) ? 1 : 0;
      end
      if (m_dec != 0 && st_old == 1 && m_e == 7) m_st = 0;
      if (m_f == 0 && m_j == 0) m_st = 2;
    end
  endtask

  // One transaction: drive, queue expectation, sample 1 time unit after the edge
  task automatic step(input logic t, input logic f, input logic p, input logic s);
    logic [13:0] e;
    tick = t; feed_pulse = f; play_pulse = p; sleep_pulse = s;
    model_step(t, f, p, s);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    feed_pulse = 1'b0; play_pulse = 1'b0; sleep_pulse = 1'b0;
    e = exp_q.pop_front();
    check_val("step", int'(dut_pack()), int'(e));
    if (decay_strobe) strobe_cnt++;
    $display("[TB] t=%0b f=%0b p=%0b s=%0b -> F%0d E%0d J%0d mood%0d slp%0b dead%0b strb%0b",
             t, f, p, s, fullness, energy, joy, mood, sleeping, dead, decay_strobe);
  endtask

  task automatic pulse_tick();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic decay_once();
    repeat (DT) pulse_tick();
  endtask

  task automatic apply_reset(input logic t);
    reset = 1'b0; tick = t;
    feed_pulse = 1'b0; play_pulse = 1'b0; sleep_pulse = 1'b0;
    model_reset();
    #1;
    check_val("async_rst", int'(dut_pack()), int'({3'd7, 3'd7, 3'd7, 5'd0}));
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold", int'(dut_pack()), int'({3'd7, 3'd7, 3'd7, 5'd0}));
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1;
    feed_pulse = 1'b0; play_pulse = 1'b0; sleep_pulse = 1'b0;
    model_reset();
    #2;

    // Reset, released with tick already high
    apply_reset(1'b1);
    strobe_cnt = 0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Decay with one tick held high for 5 cycles
    pulse_tick();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_tick();
    pulse_tick();
    check_val("decay_strobes", strobe_cnt, 1);
    check_val("decay_stats", int'({fullness, energy, joy}), int'({3'd6, 3'd6, 3'd6}));
    check_val("decay_mood", int'(mood), 0);

    // Saturation and play
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("feed_sat", int'(fullness), 7);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("play_joy", int'(joy), 7);
    check_val("play_energy", int'(energy), 5);
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("play_e0_energy", int'(energy), 0);
    check_val("play_e0_joy", int'(joy), 7);

    // Sleep and auto-wake
    apply_reset(1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("pre_sleep_energy", int'(energy), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("sleeping_on", int'(sleeping), 1);
    decay_once();
    check_val("sleep_e4", int'(energy), 4);
    decay_once();
    check_val("sleep_e6", int'(energy), 6);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("sleep_feed_ign", int'(fullness), 5);
    decay_once();
    check_val("sleep_e7", int'(energy), 7);
    check_val("auto_wake", int'(sleeping), 0);
    check_val("sleep_full", int'(fullness), 4);
    check_val("sleep_joy", int'(joy), 7);

    // Death is terminal
    apply_reset(1'b0);
    repeat (7) decay_once();
    check_val("death", int'(dut_pack()), int'({3'd0, 3'd0, 3'd0, 2'd3, 1'b0, 1'b1, 1'b1}));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    decay_once();
    check_val("dead_frozen", int'(dut_pack()), int'({3'd0, 3'd0, 3'd0, 2'd3, 1'b0, 1'b1, 1'b0}));
    apply_reset(1'b1);

    // Decay and feed in the same cycle at fullness 3
    repeat (4) decay_once();
    check_val("pre_sim_full", int'(fullness), 3);
    repeat (DT - 1) pulse_tick();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("sim_decay_feed", int'(fullness), 4);
    check_val("sim_strobe", int'(decay_strobe), 1);

    // Feed beats play
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("prio_full", int'(fullness), 6);
    check_val("prio_joy", int'(joy), 2);
    check_val("prio_energy", int'(energy), 2);

    // Reset discards a partial decay count
    repeat (3) pulse_tick();
    apply_reset(1'b0);
    strobe_cnt = 0;
    repeat (3) pulse_tick();
    check_val("partial_no_decay", strobe_cnt, 0);
    check_val("partial_full", int'(fullness), 7);
    pulse_tick();
    check_val("fresh_decay", strobe_cnt, 1);
    check_val("fresh_full", int'(fullness), 6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
